// File: rtl/instr_enc.sv
// Instruction encoder: packs MIPS-style instruction requests into 32-bit words
// and writes them sequentially into a 64-word instruction memory image.
module instr_enc (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  req_kind_i3,
    input  logic [4:0]  req_rs_i5,
    input  logic [4:0]  req_rt_i5,
    input  logic [4:0]  req_rd_i5,
    input  logic [5:0]  req_funct_i6,
    input  logic [25:0] req_imm_i26,
    output logic        imem_we_o,
    output logic [5:0]  imem_addr_o6,
    output logic [31:0] imem_wd_o32,
    output logic [6:0]  count_o7,
    output logic        full_o,
    output logic        err_o
);

    localparam logic [2:0] KIND_RTYPE = 3'd0;
    localparam logic [2:0] KIND_LW    = 3'd1;
    localparam logic [2:0] KIND_SW    = 3'd2;
    localparam logic [2:0] KIND_LUI   = 3'd3;
    localparam logic [2:0] KIND_BEQ   = 3'd4;
    localparam logic [2:0] KIND_J     = 3'd5;
    localparam logic [2:0] KIND_ADDI  = 3'd6;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    logic        accept;
    logic        legal;
    logic [31:0] enc_word;

    // Handshake: a request transfers in any cycle where req_valid_i && req_ready_o;
    // req_* fields are sampled only in that cycle, and ready never depends on valid.
    assign req_ready_o = !full_o && !err_o && !clr_i && !rst_i;
    assign accept      = req_valid_i && req_ready_o;
    assign legal       = (req_kind_i3 != 3'd7);

    always_comb begin
        enc_word = 32'd0;
        case (req_kind_i3)
            KIND_RTYPE: enc_word = {OP_RTYPE, req_rs_i5, req_rt_i5, req_rd_i5, 5'b00000, req_funct_i6};
            KIND_LW:    enc_word = {OP_LW,   req_rs_i5, req_rt_i5, req_imm_i26[15:0]};
            KIND_SW:    enc_word = {OP_SW,   req_rs_i5, req_rt_i5, req_imm_i26[15:0]};
            KIND_LUI:   enc_word = {OP_LUI,  5'b00000,  req_rt_i5, req_imm_i26[15:0]};
            KIND_BEQ:   enc_word = {OP_BEQ,  req_rs_i5, req_rt_i5, req_imm_i26[15:0]};
            KIND_J:     enc_word = {OP_J,    req_imm_i26};
            KIND_ADDI:  enc_word = {OP_ADDI, req_rs_i5, req_rt_i5, req_imm_i26[15:0]};
            default:    enc_word = 32'd0;
        endcase
    end

    // Count advances together with the registered write, so count_o7 already
    // includes a word in the cycle its strobe is visible.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            imem_we_o    <= 1'b0;
            imem_addr_o6 <= 6'd0;
            imem_wd_o32  <= 32'd0;
            count_o7     <= 7'd0;
            full_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            imem_we_o <= accept && legal;
            if (accept && legal) begin
                imem_addr_o6 <= count_o7[5:0];
                imem_wd_o32  <= enc_word;
            end
            if (clr_i) begin
                count_o7 <= 7'd0;
                full_o   <= 1'b0;
                err_o    <= 1'b0;
            end else if (accept) begin
                if (legal) begin
                    count_o7 <= count_o7 + 7'd1;
                    full_o   <= (count_o7 == 7'd63);
                end else begin
                    err_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_enc.sv
// Self-checking bench for instr_enc: directed scenarios plus randomized traffic
// checked against a word-level reference model and an expected-write queue.
module tb_instr_enc;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        valid;
    logic        ready;
    logic [2:0]  kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [25:0] imm;
    logic        we;
    logic [5:0]  addr;
    logic [31:0] wd;
    logic [6:0]  count;
    logic        full;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int          m_count;
    bit          m_full;
    bit          m_err;
    bit          m_we;
    int          m_addr;
    logic [31:0] m_wd;
    logic [37:0] exp_q[$];

    instr_enc dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .clr_i        (clr),
        .req_valid_i  (valid),
        .req_ready_o  (ready),
        .req_kind_i3  (kind),
        .req_rs_i5    (rs),
        .req_rt_i5    (rt),
        .req_rd_i5    (rd),
        .req_funct_i6 (funct),
        .req_imm_i26  (imm),
        .imem_we_o    (we),
        .imem_addr_o6 (addr),
        .imem_wd_o32  (wd),
        .count_o7     (count),
        .full_o       (full),
        .err_o        (err)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction word built with plain arithmetic from the field layout.
    function automatic logic [31:0] ref_enc(int k, int f_rs, int f_rt, int f_rd, int f_funct, int f_imm);
        longint w;
        longint op_tab[7] = '{0, 35, 43, 15, 4, 2, 8};
        longint imm16 = f_imm % 65536;
        w = 0;
        case (k)
            0:       w = longint'(f_rs) * (2**21) + longint'(f_rt) * (2**16) + longint'(f_rd) * (2**11) + f_funct;
            3:       w = op_tab[3] * (2**26) + longint'(f_rt) * (2**16) + imm16;
            5:       w = op_tab[5] * (2**26) + f_imm;
            1, 2, 4, 6: w = op_tab[k] * (2**26) + longint'(f_rs) * (2**21) + longint'(f_rt) * (2**16) + imm16;
            default: w = 0;
        endcase
        return w[31:0];
    endfunction

    function automatic bit model_ready();
        return !m_full && !m_err && !clr && !rst;
    endfunction

    // driver tasks
    task automatic drive(input bit v, input int k, input int f_rs, input int f_rt, input int f_rd,
                         input int f_funct, input int f_imm);
        valid = v;
        kind  = 3'(k);
        rs    = 5'(f_rs);
        rt    = 5'(f_rt);
        rd    = 5'(f_rd);
        funct = 6'(f_funct);
        imm   = 26'(f_imm);
    endtask

    task automatic idle();
        drive(1'b0, 0, 0, 0, 0, 0, 0);
        clr = 1'b0;
        rst = 1'b0;
    endtask

    // Advance the model over the coming edge, then step the clock.
    task automatic tick();
        bit acc;
        if (rst) begin
            m_count = 0; m_full = 0; m_err = 0; m_we = 0; m_addr = 0; m_wd = 32'd0;
            exp_q.delete();
        end else begin
            acc  = valid && model_ready();
            m_we = acc && (kind != 3'd7);
            if (m_we) begin
                m_addr = m_count % 64;
                m_wd   = ref_enc(int'(kind), int'(rs), int'(rt), int'(rd), int'(funct), int'(imm));
                exp_q.push_back({6'(m_addr), m_wd});
                m_count++;
            end
            if (acc && kind == 3'd7) m_err = 1;
            if (clr) begin
                m_count = 0;
                m_err   = 0;
            end
            m_full = (m_count == 64);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        n_checks++; if (we !== 1'b0)     begin n_fail++; $display("FAIL reset_we got %0b want 0", we); end
        n_checks++; if (addr !== 6'd0)   begin n_fail++; $display("FAIL reset_addr got %0d want 0", addr); end
        n_checks++; if (wd !== 32'd0)    begin n_fail++; $display("FAIL reset_wd got %h want 0", wd); end
        n_checks++; if (count !== 7'd0)  begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_checks++; if (full !== 1'b0)   begin n_fail++; $display("FAIL reset_full got %0b want 0", full); end
        n_checks++; if (err !== 1'b0)    begin n_fail++; $display("FAIL reset_err got %0b want 0", err); end
        n_checks++; if (ready !== 1'b0)  begin n_fail++; $display("FAIL reset_ready_in_rst got %0b want 0", ready); end
        rst = 1'b0;
        #1;
        n_checks++; if (ready !== 1'b1)  begin n_fail++; $display("FAIL reset_ready_after got %0b want 1", ready); end
        exp_q.delete();
    endtask

    task automatic test_addi();
        do_reset();
        drive(1'b1, 6, 0, 8, 0, 0, 5);
        tick();
        idle();
        n_checks++; if (we !== 1'b1)           begin n_fail++; $display("FAIL addi_we got %0b want 1", we); end
        n_checks++; if (addr !== 6'd0)         begin n_fail++; $display("FAIL addi_addr got %0d want 0", addr); end
        n_checks++; if (wd !== 32'h20080005)   begin n_fail++; $display("FAIL addi_wd got %h want 20080005", wd); end
        n_checks++; if (count !== 7'd1)        begin n_fail++; $display("FAIL addi_count got %0d want 1", count); end
        tick();
        n_checks++; if (we !== 1'b0)           begin n_fail++; $display("FAIL addi_we_drop got %0b want 0", we); end
        n_checks++; if (wd !== 32'h20080005)   begin n_fail++; $display("FAIL addi_wd_hold got %h want 20080005", wd); end
        n_checks++; if (count !== 7'd1)        begin n_fail++; $display("FAIL addi_count_hold got %0d want 1", count); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1'b1, 0, 8, 9, 10, 6'h20, 26'h3ff_ffff);
        tick();
        drive(1'b1, 1, 16, 9, 31, 6'h3f, 4);
        n_checks++; if (we !== 1'b1 || addr !== 6'd0 || wd !== 32'h01095020)
            begin n_fail++; $display("FAIL b2b_rtype got we=%0b addr=%0d wd=%h want 1/0/01095020", we, addr, wd); end
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %0b want 1", ready); end
        tick();
        n_checks++; if (we !== 1'b1 || addr !== 6'd1 || wd !== 32'h8E090004)
            begin n_fail++; $display("FAIL b2b_lw got we=%0b addr=%0d wd=%h want 1/1/8e090004", we, addr, wd); end
        drive(1'b1, 3, 7, 8, 5, 6'h11, 26'h3ff_1234);
        tick();
        n_checks++; if (we !== 1'b1 || addr !== 6'd2 || wd !== 32'h3C081234)
            begin n_fail++; $display("FAIL lui got we=%0b addr=%0d wd=%h want 1/2/3c081234", we, addr, wd); end
        drive(1'b1, 5, 31, 31, 31, 6'h3f, 26'h0000010);
        tick();
        idle();
        n_checks++; if (we !== 1'b1 || addr !== 6'd3 || wd !== 32'h08000010)
            begin n_fail++; $display("FAIL j got we=%0b addr=%0d wd=%h want 1/3/08000010", we, addr, wd); end
        n_checks++; if (count !== 7'd4) begin n_fail++; $display("FAIL b2b_count got %0d want 4", count); end
        tick();
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 64; i++) begin
            drive(1'b1, $urandom_range(0, 6), $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 26'h3ff_ffff));
            tick();
            n_checks++; if (we !== 1'b1 || addr !== 6'(i) || wd !== m_wd)
                begin n_fail++; $display("FAIL full_fill[%0d] got we=%0b addr=%0d wd=%h want 1/%0d/%h", i, we, addr, wd, i, m_wd); end
            n_checks++; if (count !== 7'(i + 1) || full !== (i == 63))
                begin n_fail++; $display("FAIL full_count[%0d] got count=%0d full=%0b want %0d/%0b", i, count, full, i + 1, i == 63); end
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 6, 1, 2, 3, 4, 5);
            #1;
            n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %0b want 0", ready); end
            tick();
            n_checks++; if (we !== 1'b0 || addr !== 6'd63 || count !== 7'd64 || full !== 1'b1)
                begin n_fail++; $display("FAIL full_hold got we=%0b addr=%0d count=%0d full=%0b want 0/63/64/1", we, addr, count, full); end
        end
        idle();
    endtask

    task automatic test_err_clr();
        do_reset();
        drive(1'b1, 6, 1, 2, 0, 0, 3);
        tick();
        drive(1'b1, 7, 1, 2, 3, 4, 5);
        tick();
        n_checks++; if (we !== 1'b0 || err !== 1'b1 || count !== 7'd1)
            begin n_fail++; $display("FAIL err_set got we=%0b err=%0b count=%0d want 0/1/1", we, err, count); end
        drive(1'b1, 6, 1, 2, 0, 0, 3);
        #1;
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL err_ready got %0b want 0", ready); end
        tick();
        n_checks++; if (we !== 1'b0 || count !== 7'd1)
            begin n_fail++; $display("FAIL err_block got we=%0b count=%0d want 0/1", we, count); end
        idle();
        clr = 1'b1;
        #1;
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL clr_ready_during got %0b want 0", ready); end
        tick();
        clr = 1'b0;
        #1;
        n_checks++; if (err !== 1'b0 || count !== 7'd0 || full !== 1'b0 || ready !== 1'b1)
            begin n_fail++; $display("FAIL clr_after got err=%0b count=%0d full=%0b ready=%0b want 0/0/0/1", err, count, full, ready); end
    endtask

    task automatic test_rst_after_accept();
        do_reset();
        drive(1'b1, 6, 4, 5, 0, 0, 16'h7777);
        tick();
        idle();
        rst = 1'b1;
        tick();
        n_checks++; if (we !== 1'b0 || addr !== 6'd0 || wd !== 32'd0)
            begin n_fail++; $display("FAIL rst_pend_write got we=%0b addr=%0d wd=%h want 0/0/0", we, addr, wd); end
        n_checks++; if (count !== 7'd0 || full !== 1'b0 || err !== 1'b0)
            begin n_fail++; $display("FAIL rst_pend_status got count=%0d full=%0b err=%0b want 0/0/0", count, full, err); end
        rst = 1'b0;
        #1;
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rst_pend_ready got %0b want 1", ready); end
        exp_q.delete();
    endtask

    // Randomized traffic, scoreboarded against the expected-write queue.
    task automatic test_random();
        logic [37:0] exp_w;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 19) == 0) ? 7 : $urandom_range(0, 6),
                  $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 63), $urandom_range(0, 26'h3ff_ffff));
            clr = ($urandom_range(0, 24) == 0) || (m_err && $urandom_range(0, 3) == 0);
            #1;
            n_checks++; if (ready !== model_ready())
                begin n_fail++; $display("FAIL rnd_ready[%0d] got %0b want %0b", i, ready, model_ready()); end
            tick();
            n_checks++; if (we !== m_we)
                begin n_fail++; $display("FAIL rnd_we[%0d] got %0b want %0b", i, we, m_we); end
            if (we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rnd_unexpected_write[%0d] got addr=%0d wd=%h want none", i, addr, wd);
                end else begin
                    exp_w = exp_q.pop_front();
                    n_checks++; if ({addr, wd} !== exp_w)
                        begin n_fail++; $display("FAIL rnd_write[%0d] got %0d/%h want %0d/%h", i, addr, wd, exp_w[37:32], exp_w[31:0]); end
                end
            end
            n_checks++; if (count !== 7'(m_count) || full !== m_full || err !== m_err)
                begin n_fail++; $display("FAIL rnd_status[%0d] got count=%0d full=%0b err=%0b want %0d/%0b/%0b", i, count, full, err, m_count, m_full, m_err); end
        end
        idle();
        n_checks++; if (exp_q.size() != 0)
            begin n_fail++; $display("FAIL rnd_missing_writes got %0d pending want 0", exp_q.size()); end
    endtask

    initial begin
        idle();
        m_count = 0; m_full = 0; m_err = 0; m_we = 0; m_addr = 0; m_wd = 32'd0;
        @(posedge clk);
        #1;
        test_reset();
        test_addi();
        test_back_to_back();
        test_full();
        test_err_clr();
        test_rst_after_accept();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
